// File: rtl/regport_arbiter_if.sv
// Bus bundle around the arbiter: two requester channels plus the shared register port.
// The arbiter takes the slave view; the environment (requesters and register file) the master view.
interface regport_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    logic            m0_req;
    logic            m0_lock;
    logic            m0_we;
    logic [AW-1:0]   m0_addr;
    logic [DW/8-1:0] m0_be;
    logic [DW-1:0]   m0_wdata;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;

    logic            m1_req;
    logic            m1_lock;
    logic            m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW/8-1:0] m1_be;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;

    logic            s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW/8-1:0] s_be;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_be, m0_wdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_be, m1_wdata,
        output s_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_req, s_we, s_addr, s_be, s_wdata
    );

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_be, m0_wdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_be, m1_wdata,
        input  s_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_req, s_we, s_addr, s_be, s_wdata
    );
endinterface

// File: rtl/regport_arbiter.sv
// Two-requester arbiter for a single-cycle register port.
// Round-robin on ties, bounded ownership lock, and one response pulse per grant a cycle later.
module regport_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 64,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    regport_arbiter_if.slave bus
);
    localparam int unsigned     CntW   = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LOCK);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;        // last granted master
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            resp_id_q, resp_id_d;
    logic            resp_pend_q, resp_pend_d;

    logic            gnt0, gnt1;
    logic [CntW-1:0] cnt_inc;
    logic            we_mux;
    logic [AW-1:0]   addr_mux;
    logic [DW/8-1:0] be_mux;
    logic [DW-1:0]   wdata_mux;

    // State and response bookkeeping registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            lock_cnt_q  <= '0;
            resp_id_q   <= 1'b0;
            resp_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            resp_id_q   <= resp_id_d;
            resp_pend_q <= resp_pend_d;
        end
    end

    // Next state: ownership entry/exit, round-robin pointer and lock run length.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lock_cnt_d  = lock_cnt_q;
        cnt_inc     = lock_cnt_q + CntW'(gnt0 | gnt1);
        resp_pend_d = gnt0 | gnt1;
        resp_id_d   = gnt1;
        case (state_q)
            StIdle: begin
                lock_cnt_d = '0;
                if (gnt0) begin
                    last_d = 1'b0;
                    if (bus.m0_lock) begin
                        state_d    = StOwn0;
                        lock_cnt_d = CntW'(1);
                    end
                end else if (gnt1) begin
                    last_d = 1'b1;
                    if (bus.m1_lock) begin
                        state_d    = StOwn1;
                        lock_cnt_d = CntW'(1);
                    end
                end
            end
            StOwn0: begin
                // last already points at the owner, so the other master wins the next tie
                if (!bus.m0_lock || (gnt0 && cnt_inc == MaxCnt)) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            StOwn1: begin
                if (!bus.m1_lock || (gnt1 && cnt_inc == MaxCnt)) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d    = StIdle;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Outputs: combinational grants and the register-port mux driven by the winner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.m0_req && bus.m1_req) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = bus.m0_req;
                    gnt1 = bus.m1_req;
                end
            end
            StOwn0:  gnt0 = bus.m0_req;
            StOwn1:  gnt1 = bus.m1_req;
            default: ;
        endcase
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        we_mux    = 1'b0;
        addr_mux  = bus.m0_addr;
        be_mux    = bus.m0_be;
        wdata_mux = bus.m0_wdata;
        if (gnt1) begin
            we_mux    = bus.m1_we;
            addr_mux  = bus.m1_addr;
            be_mux    = bus.m1_be;
            wdata_mux = bus.m1_wdata;
        end else if (gnt0) begin
            we_mux = bus.m0_we;
        end

        bus.m0_gnt  = gnt0;
        bus.m1_gnt  = gnt1;
        bus.s_req   = gnt0 | gnt1;
        bus.s_we    = we_mux;
        bus.s_addr  = addr_mux;
        bus.s_be    = be_mux;
        bus.s_wdata = wdata_mux;
    end

    // Response routing: the slave's registered data goes to whoever was granted last cycle.
    always_comb begin
        bus.m0_rvalid = rst_n & resp_pend_q & ~resp_id_q;
        bus.m1_rvalid = rst_n & resp_pend_q & resp_id_q;
        bus.m0_rdata  = bus.s_rdata;
        bus.m1_rdata  = bus.s_rdata;
    end
endmodule

// File: tb/tb_regport_arbiter.sv
// Bench for regport_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (owner / run length / round-robin pointer / shadow memory).
module tb_regport_arbiter;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 64;
    localparam int unsigned BW       = DW / 8;
    localparam int          MAX_LOCK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regport_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regport_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic          req   [2];
    logic          lock  [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [BW-1:0] be    [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] s_rdata;

    assign bus.m0_req   = req[0];
    assign bus.m0_lock  = lock[0];
    assign bus.m0_we    = we[0];
    assign bus.m0_addr  = addr[0];
    assign bus.m0_be    = be[0];
    assign bus.m0_wdata = wdata[0];
    assign bus.m1_req   = req[1];
    assign bus.m1_lock  = lock[1];
    assign bus.m1_we    = we[1];
    assign bus.m1_addr  = addr[1];
    assign bus.m1_be    = be[1];
    assign bus.m1_wdata = wdata[1];
    assign bus.s_rdata  = s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DW-1:0] Rd08 = 64'h0123_4567_89AB_CDEF;

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd,
                                            logic [BW-1:0] b);
        logic [DW-1:0] r = old;
        for (int i = 0; i < BW; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Register-file emulation: fed by the DUT's register port, returns data one cycle later.
    logic [DW-1:0] slv_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) slv_mem[i] = '0;
        slv_mem[1] = Rd08;
    end
    always @(posedge clk) begin
        logic [5:0] ix;
        ix = bus.s_addr[8:3];
        if (bus.s_req && !bus.s_we) begin
            s_rdata <= slv_mem[ix];
        end else begin
            s_rdata <= {$urandom, $urandom};
            if (bus.s_req) slv_mem[ix] <= merge(slv_mem[ix], bus.s_wdata, bus.s_be);
        end
    end

    // Reference model
    int            owner;      // -1 when nobody holds the lock
    int            run;        // grants in the current locked run
    int            last;
    int            exp_rv;     // master owed a response this cycle, -1 none
    logic          exp_read;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] ref_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        ref_mem[1] = Rd08;
    end

    function automatic int model_grant();
        if (owner >= 0) return req[owner] ? owner : -1;
        if (req[0] && req[1]) return 1 - last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] onehot(int m);
        return (m == 0) ? 2'b01 : (m == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_commit(int g);
        logic [AW-1:0] a;
        if (g >= 0) last = g;
        if (owner < 0) begin
            if (g >= 0 && lock[g]) begin
                owner = g;
                run   = 1;
            end
        end else begin
            if (g == owner) run++;
            if (!lock[owner] || run == MAX_LOCK) begin
                owner = -1;
                run   = 0;
            end
        end
        exp_rv   = g;
        exp_read = 1'b0;
        if (g >= 0) begin
            a         = addr[g];
            exp_read  = !we[g];
            exp_rdata = ref_mem[a[8:3]];
            if (we[g]) ref_mem[a[8:3]] = merge(ref_mem[a[8:3]], wdata[g], be[g]);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        run    = 0;
        last   = 1;
        exp_rv = -1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            req[m]   = 1'b0;
            lock[m]  = 1'b0;
            we[m]    = 1'b0;
            addr[m]  = '0;
            be[m]    = '1;
            wdata[m] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req[0]  = 1'b1;
        req[1]  = 1'b1;
        lock[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_gnt: got %b expected 00", {bus.m1_gnt, bus.m0_gnt});
            end
            n_checks++;
            if (bus.s_req !== 1'b0 || bus.s_we !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sreq: got req=%b we=%b expected 0", bus.s_req, bus.s_we);
            end
            n_checks++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_rvalid: got %b expected 00",
                         {bus.m1_rvalid, bus.m0_rvalid});
            end
            next_cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.s_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: got rv=%b sreq=%b expected 0",
                     {bus.m1_rvalid, bus.m0_rvalid}, bus.s_req);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        idle_inputs();
        req[0]  = 1'b1;
        addr[0] = 32'h08;
        @(negedge clk);
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01 || bus.s_addr !== 32'h08 || bus.s_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gnt: got gnt=%b addr=%h we=%b expected 01/00000008/0",
                     {bus.m1_gnt, bus.m0_gnt}, bus.s_addr, bus.s_we);
        end
        model_commit(model_grant());
        next_cycle();
        req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b01 || bus.m0_rdata !== Rd08) begin
            n_fail++;
            $display("FAIL single_resp: got rv=%b rdata=%h expected 01/%h",
                     {bus.m1_rvalid, bus.m0_rvalid}, bus.m0_rdata, Rd08);
        end
        model_commit(model_grant());
        next_cycle();
    endtask

    task automatic test_contention();
        int g;
        do_reset();
        req[0]  = 1'b1;
        req[1]  = 1'b1;
        addr[0] = 32'h100;
        addr[1] = 32'h180;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) idle_inputs();
            @(negedge clk);
            g = model_grant();
            n_checks++;
            if (i < 8 && ({bus.m1_gnt, bus.m0_gnt} !== onehot(i % 2)
                          || bus.s_addr !== addr[i % 2])) begin
                n_fail++;
                $display("FAIL contention_gnt[%0d]: got gnt=%b addr=%h expected %b/%h", i,
                         {bus.m1_gnt, bus.m0_gnt}, bus.s_addr, onehot(i % 2), addr[i % 2]);
            end
            n_checks++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== onehot(exp_rv)) begin
                n_fail++;
                $display("FAIL contention_rvalid[%0d]: got %b expected %b", i,
                         {bus.m1_rvalid, bus.m0_rvalid}, onehot(exp_rv));
            end
            model_commit(g);
            next_cycle();
            if (g >= 0) addr[g] = addr[g] + 32'h8;
        end
    endtask

    task automatic test_lock_voluntary();
        logic [1:0]    exp_g [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        logic [BW-1:0] bes   [3] = '{8'h0F, 8'hF0, 8'hFF};
        logic [DW-1:0] wds   [3] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                     64'hAAAA_BBBB_CCCC_DDDD};
        int g;
        do_reset();
        req[0]  = 1'b1;
        addr[0] = 32'h30;
        for (int i = 0; i < 6; i++) begin
            if (i >= 1 && i <= 3) begin
                req[1]   = 1'b1;
                we[1]    = 1'b1;
                addr[1]  = 32'h28;
                be[1]    = bes[i-1];
                wdata[1] = wds[i-1];
                lock[1]  = (i < 3);
                req[0]   = 1'b1;
                addr[0]  = 32'h28;
            end else if (i == 4) begin
                req[1]  = 1'b0;
                lock[1] = 1'b0;
            end else if (i == 5) begin
                req[0] = 1'b0;
            end
            @(negedge clk);
            g = model_grant();
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== exp_g[i]) begin
                n_fail++;
                $display("FAIL lockvol_gnt[%0d]: got %b expected %b", i,
                         {bus.m1_gnt, bus.m0_gnt}, exp_g[i]);
            end
            n_checks++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== onehot(exp_rv)) begin
                n_fail++;
                $display("FAIL lockvol_rvalid[%0d]: got %b expected %b", i,
                         {bus.m1_rvalid, bus.m0_rvalid}, onehot(exp_rv));
            end
            if (i == 5) begin
                n_checks++;
                if (bus.m0_rdata !== wds[2]) begin
                    n_fail++;
                    $display("FAIL lockvol_rdata: got %h expected %h", bus.m0_rdata, wds[2]);
                end
            end
            model_commit(g);
            next_cycle();
        end
    endtask

    task automatic test_lock_forced();
        logic [1:0] exp_g [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                   2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        int g;
        do_reset();
        req[0]  = 1'b1;
        lock[0] = 1'b1;
        addr[0] = 32'h50;
        addr[1] = 32'h58;
        for (int i = 0; i < 10; i++) begin
            req[1] = (i != 5);
            @(negedge clk);
            g = model_grant();
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== exp_g[i]) begin
                n_fail++;
                $display("FAIL lockforce_gnt[%0d]: got %b expected %b", i,
                         {bus.m1_gnt, bus.m0_gnt}, exp_g[i]);
            end
            model_commit(g);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL lockforce_rvalid: got %b expected 10", {bus.m1_rvalid, bus.m0_rvalid});
        end
        model_commit(model_grant());
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req[1]   = 1'b1;
        lock[1]  = 1'b1;
        we[1]    = 1'b1;
        addr[1]  = 32'h60;
        wdata[1] = 64'h0F0F_0F0F_0F0F_0F0F;
        @(negedge clk);
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_gnt: got %b expected 10", {bus.m1_gnt, bus.m0_gnt});
        end
        model_commit(model_grant());
        next_cycle();
        rst_n  = 1'b0;
        req[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_during: got rv/gnt=%b expected 0000",
                     {bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt});
        end
        next_cycle();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_dropped: got %b expected 00", {bus.m1_rvalid, bus.m0_rvalid});
        end
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_tie: got %b expected 01", {bus.m1_gnt, bus.m0_gnt});
        end
        model_commit(model_grant());
        next_cycle();
        idle_inputs();
        model_commit(model_grant());
        next_cycle();
    endtask

    task automatic test_back_to_back();
        localparam logic [DW-1:0] Wd = 64'hDEAD_BEEF_CAFE_F00D;
        do_reset();
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'h40;
        be[0]    = 8'hFF;
        wdata[0] = Wd;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) we[0] = 1'b0;
            if (i == 2) req[0] = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== ((i < 2) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, {bus.m1_gnt, bus.m0_gnt},
                         (i < 2) ? 2'b01 : 2'b00);
            end
            n_checks++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== ((i > 0) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i,
                         {bus.m1_rvalid, bus.m0_rvalid}, (i > 0) ? 2'b01 : 2'b00);
            end
            if (i == 2) begin
                n_checks++;
                if (bus.m0_rdata !== Wd) begin
                    n_fail++;
                    $display("FAIL b2b_rdata: got %h expected %h", bus.m0_rdata, Wd);
                end
            end
            model_commit(model_grant());
            next_cycle();
        end
    endtask

    task automatic test_random();
        int g;
        int last_g = -1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!req[m] || last_g == m) begin
                    req[m]   = ($urandom_range(0, 3) != 0);
                    we[m]    = 1'($urandom_range(0, 1));
                    addr[m]  = 32'($urandom_range(0, 15)) << 3;
                    be[m]    = 8'($urandom);
                    wdata[m] = {$urandom, $urandom};
                end
                lock[m] = ($urandom_range(0, 9) < 7);
            end
            @(negedge clk);
            g = model_grant();
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== onehot(g) || bus.s_req !== (g >= 0)) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got gnt=%b sreq=%b expected %b", i,
                         {bus.m1_gnt, bus.m0_gnt}, bus.s_req, onehot(g));
            end
            if (g >= 0) begin
                n_checks++;
                if (bus.s_addr !== addr[g] || bus.s_we !== we[g] || bus.s_be !== be[g]
                    || bus.s_wdata !== wdata[g]) begin
                    n_fail++;
                    $display("FAIL rand_port[%0d]: got %h/%b/%h/%h expected %h/%b/%h/%h", i,
                             bus.s_addr, bus.s_we, bus.s_be, bus.s_wdata,
                             addr[g], we[g], be[g], wdata[g]);
                end
            end else begin
                n_checks++;
                if (bus.s_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_swe_idle[%0d]: got %b expected 0", i, bus.s_we);
                end
            end
            n_checks++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== onehot(exp_rv)) begin
                n_fail++;
                $display("FAIL rand_rvalid[%0d]: got %b expected %b", i,
                         {bus.m1_rvalid, bus.m0_rvalid}, onehot(exp_rv));
            end
            if (exp_rv >= 0 && exp_read) begin
                n_checks++;
                if (((exp_rv == 0) ? bus.m0_rdata : bus.m1_rdata) !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d]: got %h expected %h", i,
                             (exp_rv == 0) ? bus.m0_rdata : bus.m1_rdata, exp_rdata);
                end
            end
            model_commit(g);
            last_g = g;
            next_cycle();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_contention();
        test_lock_voluntary();
        test_lock_forced();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
